// File: rtl/des_job_arbiter.sv
`default_nettype none
// ============================================================================
//  Module     : des_job_arbiter
//  Description: Shares one encrypt-only DES core between two requesters
//               (port 0 = ICB side, port 1 = APB side). Round-robin grant,
//               one job in flight, timeout on a missing result, and a
//               post-reset flush window that drains any job the core (which
//               has no reset) may still be working on.
//  Ports      : clk, rst_n (async, active low)
//               reqN_vld/rdy/data/key   - request handshake, N = 0,1
//               rspN_vld/rdy/data/err   - response handshake, N = 0,1
//               core_data/key/vld       - job issue to the core (1-cycle vld)
//               core_result/result_vld  - core result pulse
//               busy                    - high whenever not IDLE
//  Revision   : 1.0  initial release
// ============================================================================
module des_job_arbiter #(
    parameter int DATA_W  = 64,
    parameter int KEY_W   = 64,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_vld,
    output logic              req0_rdy,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [KEY_W-1:0]  req0_key,
    input  logic              req1_vld,
    output logic              req1_rdy,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [KEY_W-1:0]  req1_key,
    output logic              rsp0_vld,
    input  logic              rsp0_rdy,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_err,
    output logic              rsp1_vld,
    input  logic              rsp1_rdy,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_err,
    output logic [DATA_W-1:0] core_data,
    output logic [KEY_W-1:0]  core_key,
    output logic              core_vld,
    input  logic [DATA_W-1:0] core_result,
    input  logic              core_result_vld,
    output logic              busy
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_FLUSH_LAST = c_CNT_W'(TIMEOUT - 1);
    // The counter is tested before it increments, so matching TIMEOUT-2 here
    // is the cycle in which it would reach TIMEOUT-1.
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST  = c_CNT_W'(TIMEOUT - 2);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_FLUSH = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic                r_owner;
    logic                r_last_grant;
    logic                r_err;
    logic                r_busy;
    logic [DATA_W-1:0]   r_job_data;
    logic [KEY_W-1:0]    r_job_key;
    logic [DATA_W-1:0]   r_rsp_data;

    logic                w_grant;
    logic                w_accept;
    logic                w_owner_rdy;
    logic                w_timeout;

    // Grant selection: a lone requester wins; on a tie the port that was not
    // served last wins.
    always_comb begin
        w_grant = ~r_last_grant;
        if (req0_vld && !req1_vld) begin
            w_grant = 1'b0;
        end else if (!req0_vld && req1_vld) begin
            w_grant = 1'b1;
        end
    end

    assign req0_rdy    = (r_state == S_IDLE) && req0_vld && !w_grant;
    assign req1_rdy    = (r_state == S_IDLE) && req1_vld &&  w_grant;
    assign w_accept    = req0_rdy || req1_rdy;
    assign w_owner_rdy = r_owner ? rsp1_rdy : rsp0_rdy;
    assign w_timeout   = (r_cnt == c_WAIT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_FLUSH: begin
                if (r_cnt == c_FLUSH_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = '0;
            end
            S_WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (core_result_vld || w_timeout) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            S_RESP: begin
                if (w_owner_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_FLUSH;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FLUSH;
            r_cnt        <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_job_data   <= '0;
            r_job_key    <= '0;
            r_rsp_data   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Registered from the next state so busy reads 0 while in reset
            // and tracks the state exactly from the first clock onward.
            r_busy  <= (w_state_nxt != S_IDLE);
            if (w_accept) begin
                r_owner    <= w_grant;
                r_job_data <= w_grant ? req1_data : req0_data;
                r_job_key  <= w_grant ? req1_key  : req0_key;
            end
            if (r_state == S_WAIT) begin
                if (core_result_vld) begin
                    r_rsp_data <= core_result;
                    r_err      <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_data <= '0;
                    r_err      <= 1'b1;
                end
            end
            if ((r_state == S_RESP) && w_owner_rdy) begin
                r_last_grant <= r_owner;
            end
        end
    end

    assign core_vld  = (r_state == S_ISSUE);
    assign core_data = r_job_data;
    assign core_key  = r_job_key;

    // Response fields are gated so the non-owner port always reads zero.
    assign rsp0_vld  = (r_state == S_RESP) && !r_owner;
    assign rsp1_vld  = (r_state == S_RESP) &&  r_owner;
    assign rsp0_data = rsp0_vld ? r_rsp_data : '0;
    assign rsp1_data = rsp1_vld ? r_rsp_data : '0;
    assign rsp0_err  = rsp0_vld && r_err;
    assign rsp1_err  = rsp1_vld && r_err;

    assign busy = r_busy;

endmodule
`default_nettype wire
